// File: rtl/add_sub_pipe.sv
// add_sub_pipe: WIDTH-bit add/subtract with the carry chain cut into STAGES
// registered slices, valid/ready flow control, N/Z/C/V flags and a pass-through tag.
module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             zero_o,
    output logic             neg_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int SLICE = WIDTH / STAGES;

    logic             en_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;

    // Subtraction is a + ~b + 1; the carry variants take the caller's carry-in
    always_comb begin
        b_eff_s = b_i;
        c0_s    = 1'b0;
        case (op_i)
            2'b00: begin
                b_eff_s = b_i;
                c0_s    = 1'b0;
            end
            2'b01: begin
                b_eff_s = ~b_i;
                c0_s    = 1'b1;
            end
            2'b10: begin
                b_eff_s = b_i;
                c0_s    = cin_i;
            end
            2'b11: begin
                b_eff_s = ~b_i;
                c0_s    = cin_i;
            end
            default: begin
                b_eff_s = b_i;
                c0_s    = 1'b0;
            end
        endcase
    end

    // One global advance: the whole pipe moves or the whole pipe holds
    assign en_s       = ~out_valid_o | out_ready_i;
    assign in_ready_o = en_s;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int HI_W  = WIDTH - s * SLICE;
        localparam int SUM_W = (s + 1) * SLICE;

        logic [HI_W-1:0]  a_in_s;
        logic [HI_W-1:0]  b_in_s;
        logic             carry_in_s;
        logic             zero_in_s;
        logic             valid_in_s;
        logic [TAG_W-1:0] tag_in_s;
        logic [SLICE:0]   slice_s;
        logic [SUM_W-1:0] sum_nxt_s;

        logic             valid_r;
        logic             carry_r;
        logic             zero_r;
        logic [TAG_W-1:0] tag_r;
        logic [SUM_W-1:0] sum_r;

        if (s == 0) begin : g_src
            assign a_in_s     = a_i;
            assign b_in_s     = b_eff_s;
            assign carry_in_s = c0_s;
            assign zero_in_s  = 1'b1;
            assign valid_in_s = in_valid_i;
            assign tag_in_s   = tag_i;
            assign sum_nxt_s  = slice_s[SLICE-1:0];
        end else begin : g_src
            assign a_in_s     = g_stage[s-1].g_skew.a_rem_r;
            assign b_in_s     = g_stage[s-1].g_skew.b_rem_r;
            assign carry_in_s = g_stage[s-1].carry_r;
            assign zero_in_s  = g_stage[s-1].zero_r;
            assign valid_in_s = g_stage[s-1].valid_r;
            assign tag_in_s   = g_stage[s-1].tag_r;
            assign sum_nxt_s  = {slice_s[SLICE-1:0], g_stage[s-1].sum_r};
        end

        assign slice_s = {1'b0, a_in_s[SLICE-1:0]} + {1'b0, b_in_s[SLICE-1:0]}
                       + {{SLICE{1'b0}}, carry_in_s};

        // Slice result, carry, running zero, tag and valid for this stage
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_r <= 1'b0;
                carry_r <= 1'b0;
                zero_r  <= 1'b0;
                tag_r   <= {TAG_W{1'b0}};
                sum_r   <= {SUM_W{1'b0}};
            end else if (en_s) begin
                valid_r <= valid_in_s;
                carry_r <= slice_s[SLICE];
                zero_r  <= zero_in_s & (slice_s[SLICE-1:0] == {SLICE{1'b0}});
                tag_r   <= tag_in_s;
                sum_r   <= sum_nxt_s;
            end
        end

        if (s < STAGES - 1) begin : g_skew
            logic [HI_W-SLICE-1:0] a_rem_r;
            logic [HI_W-SLICE-1:0] b_rem_r;

            // Upper operand slices ride along until their stage consumes them
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    a_rem_r <= {(HI_W - SLICE){1'b0}};
                    b_rem_r <= {(HI_W - SLICE){1'b0}};
                end else if (en_s) begin
                    a_rem_r <= a_in_s[HI_W-1:SLICE];
                    b_rem_r <= b_in_s[HI_W-1:SLICE];
                end
            end
        end

        if (s == STAGES - 1) begin : g_last
            logic ovf_r;

            // Signed overflow: equal operand signs, result sign differs
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    ovf_r <= 1'b0;
                end else if (en_s) begin
                    ovf_r <= ~(a_in_s[HI_W-1] ^ b_in_s[HI_W-1])
                           & (a_in_s[HI_W-1] ^ slice_s[SLICE-1]);
                end
            end
        end
    end

    assign out_valid_o = g_stage[STAGES-1].valid_r;
    assign sum_o       = g_stage[STAGES-1].sum_r;
    assign cout_o      = g_stage[STAGES-1].carry_r;
    assign zero_o      = g_stage[STAGES-1].zero_r;
    assign neg_o       = g_stage[STAGES-1].sum_r[WIDTH-1];
    assign ovf_o       = g_stage[STAGES-1].g_last.ovf_r;
    assign tag_o       = g_stage[STAGES-1].tag_r;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe at (32,4), (32,1) and (64,8): drivers push
// reference results on input transfer, monitors pop and compare on output transfer.
module tb_add_sub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int cfg_w(input int i);
        return (i == 2) ? 64 : 32;
    endfunction

    function automatic int cfg_s(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 1 : 8);
    endfunction

    for (genvar C = 0; C < 3; C++) begin : g_cfg
        localparam int W  = cfg_w(C);
        localparam int S  = cfg_s(C);
        localparam int TW = 4;
        localparam int EW = W + TW + 4;
        localparam logic signed [W+1:0] MAXP = {3'b000, {(W-1){1'b1}}};
        localparam logic signed [W+1:0] MINN = {3'b111, {(W-1){1'b0}}};
        localparam logic [W-1:0] MAXW = {1'b0, {(W-1){1'b1}}};
        localparam logic [W-1:0] MINW = {1'b1, {(W-1){1'b0}}};

        logic          rst_n;
        logic          in_valid, in_ready, cin, out_valid, out_ready;
        logic [1:0]    op_in;
        logic [W-1:0]  a_in, b_in, sum;
        logic [TW-1:0] tag_in, tag_out;
        logic          cout, ovf, zero, neg;
        logic [EW-1:0] q[$];
        logic          blk_done = 1'b0;

        add_sub_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .in_valid_i(in_valid), .in_ready_o(in_ready),
            .op_i(op_in), .a_i(a_in), .b_i(b_in), .cin_i(cin), .tag_i(tag_in),
            .out_valid_o(out_valid), .out_ready_i(out_ready),
            .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .zero_o(zero), .neg_o(neg),
            .tag_o(tag_out)
        );

        // Reference: exact integer arithmetic with headroom, packed {tag,N,Z,V,C,sum}
        function automatic logic [EW-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input logic cin_v,
                                                input logic [TW-1:0] tag);
            logic [W:0] ua, ub, ci, bw, ur;
            logic signed [W+1:0] sa, sb, sr;
            logic c, v;
            ua = {1'b0, a};
            ub = {1'b0, b};
            ci = {{W{1'b0}}, cin_v};
            bw = {{W{1'b0}}, ~cin_v};
            sa = {{2{a[W-1]}}, a};
            sb = {{2{b[W-1]}}, b};
            case (op)
                2'b00:   begin ur = ua + ub;      sr = sa + sb;                             c = ur[W];  end
                2'b01:   begin ur = ua - ub;      sr = sa - sb;                             c = ~ur[W]; end
                2'b10:   begin ur = ua + ub + ci; sr = sa + sb + $signed({1'b0, ci});       c = ur[W];  end
                default: begin ur = ua - ub - bw; sr = sa - sb - $signed({1'b0, bw});       c = ~ur[W]; end
            endcase
            v = (sr > MAXP) || (sr < MINN);
            return {tag, ur[W-1], (ur[W-1:0] == '0), v, c, ur[W-1:0]};
        endfunction

        function automatic logic [W-1:0] pick();
            logic [W-1:0] r;
            for (int i = 0; i < W; i += 32) r[i +: 32] = $urandom();
            case ($urandom_range(0, 5))
                0: return '0;
                1: return '1;
                2: return MAXW;
                3: return MINW;
                default: return r;
            endcase
        endfunction

        task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin_v, input logic [TW-1:0] tag, input bit rnd_rdy);
            bit acc = 1'b0;
            for (int n = 0; n < 64 && !acc; n++) begin
                @(negedge clk);
                in_valid = 1'b1; op_in = op; a_in = a; b_in = b; cin = cin_v; tag_in = tag;
                out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
                #1;
                acc = in_ready;
                @(posedge clk);
                if (acc) q.push_back(model(op, a, b, cin_v, tag));
            end
            if (!acc) chk($sformatf("c%0d_send_timeout", C), 128'(0), 128'(1));
        endtask

        task automatic idle(input bit rnd_rdy);
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        endtask

        task automatic drain();
            for (int n = 0; n < 400 && q.size() != 0; n++) idle(1'b0);
            chk($sformatf("c%0d_drain_left", C), 128'(q.size()), 128'(0));
            idle(1'b0);
        endtask

        task automatic random_ops(input int n_ops);
            for (int i = 0; i < n_ops; i++) begin
                if ($urandom_range(0, 3) != 0)
                    send(2'($urandom_range(0, 3)), pick(), pick(), 1'($urandom_range(0, 1)),
                         4'($urandom_range(0, 15)), 1'b1);
                else
                    idle(1'b1);
            end
        endtask

        // Driver: directed cases, back-pressure stream, random traffic, reset mid-flight
        initial begin : drv
            int lat;
            int sent;
            int stall_left;
            bit started, acc;
            logic [1:0] op_v;
            logic [W-1:0] a_v, b_v;
            logic c_v;
            rst_n = 1'b0; in_valid = 1'b0; op_in = 2'b00; a_in = '0; b_in = '0;
            cin = 1'b0; tag_in = '0; out_ready = 1'b0;
            repeat (2) @(negedge clk);
            #1;
            chk($sformatf("c%0d_rst_valid", C), 128'(out_valid), 128'(0));
            chk($sformatf("c%0d_rst_sum", C), 128'(sum), 128'(0));
            chk($sformatf("c%0d_rst_flags", C), 128'({neg, zero, ovf, cout}), 128'(0));
            chk($sformatf("c%0d_rst_tag", C), 128'(tag_out), 128'(0));
            chk($sformatf("c%0d_rst_ready", C), 128'(in_ready), 128'(1));
            @(negedge clk);
            rst_n = 1'b1;

            send(2'b00, W'(255), W'(1), 1'b0, 4'd3, 1'b0);
            lat = -1;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                in_valid = 1'b0; out_ready = 1'b1;
                #1;
                if (out_valid) begin lat = k; break; end
            end
            chk($sformatf("c%0d_latency", C), 128'(lat), 128'(S - 1));
            chk($sformatf("c%0d_first_sum", C), 128'(sum), 128'(256));
            chk($sformatf("c%0d_first_tag", C), 128'(tag_out), 128'(3));
            chk($sformatf("c%0d_first_flags", C), 128'({neg, zero, ovf, cout}), 128'(0));

            send(2'b00, MAXW, W'(1), 1'b0, 4'd1, 1'b0);
            send(2'b00, '1, W'(1), 1'b0, 4'd2, 1'b0);
            send(2'b01, W'(5), W'(7), 1'b1, 4'd4, 1'b0);
            send(2'b01, W'(7), W'(5), 1'b0, 4'd5, 1'b0);
            send(2'b01, MINW, W'(1), 1'b0, 4'd6, 1'b0);
            send(2'b10, '1, '0, 1'b1, 4'd7, 1'b0);
            send(2'b11, '0, '0, 1'b0, 4'd8, 1'b0);
            send(2'b00, W'(1), W'(1), 1'b1, 4'd9, 1'b0);
            send(2'b11, W'(7), W'(5), 1'b1, 4'd10, 1'b0);
            send(2'b10, MAXW, '0, 1'b1, 4'd11, 1'b0);
            drain();
            repeat (S + 2) idle(1'b0);

            // Eight back-to-back ops, output stalled for five cycles once results appear
            sent = 0; stall_left = 5; started = 1'b0;
            for (int cyc = 0; cyc < 200 && (sent < 8 || stall_left > 0); cyc++) begin
                @(negedge clk);
                if (out_valid) started = 1'b1;
                op_v = 2'($urandom_range(0, 3)); a_v = pick(); b_v = pick();
                c_v = 1'($urandom_range(0, 1));
                in_valid = (sent < 8); op_in = op_v; a_in = a_v; b_in = b_v; cin = c_v;
                tag_in = sent[3:0];
                out_ready = !(started && stall_left > 0);
                #1;
                if (started && q.size() != 0)
                    chk($sformatf("c%0d_no_bubble", C), 128'(out_valid), 128'(1));
                if (!out_ready)
                    chk($sformatf("c%0d_stall_in_ready", C), 128'(in_ready), 128'(0));
                acc = in_valid && in_ready;
                if (started && stall_left > 0) stall_left--;
                @(posedge clk);
                if (acc) begin
                    q.push_back(model(op_v, a_v, b_v, c_v, sent[3:0]));
                    sent++;
                end
            end
            chk($sformatf("c%0d_stream_sent", C), 128'(sent), 128'(8));
            drain();

            random_ops(60);
            drain();

            send(2'b00, pick(), pick(), 1'b0, 4'd12, 1'b0);
            send(2'b01, pick(), pick(), 1'b0, 4'd13, 1'b0);
            send(2'b10, pick(), pick(), 1'b1, 4'd14, 1'b0);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            rst_n = 1'b0;
            #1;
            chk($sformatf("c%0d_midrst_valid", C), 128'(out_valid), 128'(0));
            chk($sformatf("c%0d_midrst_sum", C), 128'(sum), 128'(0));
            q.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (S + 2) idle(1'b0);
            random_ops(20);
            drain();
            repeat (S + 2) idle(1'b0);
            blk_done = 1'b1;
        end

        // Monitor: compare on every output transfer, check holds across stalls
        initial begin : mon
            logic [EW-1:0] held, cur, e;
            bit stall_prev;
            stall_prev = 1'b0;
            held = '0;
            forever begin
                @(negedge clk);
                #2;
                cur = {tag_out, neg, zero, ovf, cout, sum};
                if (!rst_n) begin
                    stall_prev = 1'b0;
                end else begin
                    chk($sformatf("c%0d_in_ready", C), 128'(in_ready), 128'(!out_valid || out_ready));
                    if (stall_prev) chk($sformatf("c%0d_hold", C), 128'(cur), 128'(held));
                    stall_prev = 1'b0;
                    if (out_valid) begin
                        if (out_ready) begin
                            if (q.size() == 0) begin
                                chk($sformatf("c%0d_unexpected_result", C), 128'(1), 128'(0));
                            end else begin
                                e = q.pop_front();
                                chk($sformatf("c%0d_result", C), 128'(cur), 128'(e));
                            end
                        end else begin
                            stall_prev = 1'b1;
                            held = cur;
                        end
                    end
                end
            end
        end
    end

    initial begin : summary
        for (int n = 0; n < 40000; n++) begin
            @(posedge clk);
            if (g_cfg[0].blk_done && g_cfg[1].blk_done && g_cfg[2].blk_done) break;
        end
        if (!(g_cfg[0].blk_done && g_cfg[1].blk_done && g_cfg[2].blk_done))
            chk("global_timeout", 128'(0), 128'(1));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
